// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for pipeline stage registers
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
    localparam int PIPE_CNT_W = 16;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: valid + instr + pc register with load and clear
module pipe_entry #(
    parameter int DATA_W = 32,
    parameter int PC_W = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [PC_W-1:0]   d_pc,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   pc
);
    always_ff @(negedge clk)
        if (rst || clr) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc <= d_pc;
        end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with skid entry, flush and stall counter
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int PC_W = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(MIPS_NOP),
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic main_v, skid_v, accept, fire, main_ld, main_clr, skid_ld, skid_clr;
    logic [DATA_W-1:0] skid_instr;
    logic [PC_W-1:0] skid_pc;
    pipe_state_t state;

    assign in_ready = !skid_v;
    assign out_valid = main_v;
    assign accept = in_valid && in_ready;
    assign fire = main_v && out_ready;
    assign state = skid_v ? FULL : main_v ? ONE : EMPTY;

    // Main refills from skid when skid is occupied, otherwise straight from the input.
    assign main_ld = !flush && (skid_v ? fire : accept && (!main_v || fire));
    assign main_clr = flush || (fire && !skid_v && !accept);
    assign skid_ld = !flush && main_v && !skid_v && accept && !fire;
    assign skid_clr = flush || (skid_v && fire);

    pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_main (
        .clk(clk), .rst(rst), .clr(main_clr), .load(main_ld),
        .d_instr(skid_v ? skid_instr : in_instr), .d_pc(skid_v ? skid_pc : in_pc),
        .valid(main_v), .instr(out_instr), .pc(out_pc)
    );

    pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk(clk), .rst(rst), .clr(skid_clr), .load(skid_ld),
        .d_instr(in_instr), .d_pc(in_pc),
        .valid(skid_v), .instr(skid_instr), .pc(skid_pc)
    );

    always_ff @(negedge clk)
        if (rst)
            stall_cnt <= '0;
        else if (main_v && !out_ready && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;

    // Skid may only hold an entry while main does.
    assert property (@(negedge clk) disable iff (rst) state == FULL |-> main_v);
endmodule
